fifo_word_serializer: RTL
=========================

// Module: fifo_word_serializer
// PURPOSE
//   Downstream drain stage for the 4-deep word FIFO. Pops in_width-bit words and emits
//   them as out_width-bit beats on a valid/ready stream, marking each word's last beat.
//   Back-to-back words stream with no bubble when the FIFO stays non-empty.
// PARAMETERS
//   in_width   32  width of FIFO words; must be an integer multiple of out_width
//   out_width  8   width of each output beat
//   msb_first  0   0: emit bits [out_width-1:0] first; 1: emit top slice first
//   cnt_width  16  width of the words_sent counter
// PORTS
//   clk         in   1           clock, all state updates on rising edge
//   reset       in   1           synchronous, active-high reset
//   fifo_empty  in   1           FIFO empty flag
//   fifo_data   in   in_width    FIFO head word, valid while fifo_empty=0
//   fifo_pop    out  1           pop strobe to FIFO; head is consumed at this clk edge
//   out_valid   out  1           out_data/out_last valid
//   out_ready   in   1           sink accepts the beat when out_valid && out_ready
//   out_data    out  out_width   current beat
//   out_last    out  1           high on final beat of a word
//   busy        out  1           high while a word is held (state SEND)
//   words_sent  out  cnt_width   count of fully transmitted words, wraps modulo 2**cnt_width
// BEHAVIOUR
//   - RATIO = in_width/out_width. The beat counter is $clog2(RATIO) bits, minimum 1 bit.
//   - Reset (clk edge with reset=1): state=IDLE, shreg=0, beat_cnt=0, words_sent=0.
//     Outputs: out_valid=0, out_data=0, out_last=0, busy=0, fifo_pop=0.
//   - fifo_pop is combinational. It is forced 0 while reset=1 and is never 1 when fifo_empty=1.
//   - FSM IDLE:
//       - If fifo_empty=0: fifo_pop=1, shreg<=fifo_data, beat_cnt<=0, and the FSM goes to SEND.
//       - Otherwise the FSM stays in IDLE.
//   - FSM SEND:
//       - out_valid=1, busy=1.
//       - out_data = shreg[out_width-1:0], or shreg[in_width-1 -: out_width] if msb_first.
//       - out_last = (beat_cnt==RATIO-1).
//   - SEND, accept of a non-last beat: shreg shifts by out_width toward the emit end,
//     zero-filled, and beat_cnt increments.
//   - SEND, accept of the last beat:
//       - words_sent increments in every case.
//       - If fifo_empty=0: fifo_pop=1 in the same cycle, shreg<=fifo_data, beat_cnt<=0,
//         and the FSM stays in SEND (zero-bubble).
//       - Otherwise the FSM goes to IDLE.
//   - Stall: while out_valid && !out_ready, out_data, out_last and the state hold.
//     out_valid never depends on out_ready. No pop occurs during a stall.
//   - Latency: fifo_empty falls in cycle N with the FSM in IDLE -> out_valid=1 in cycle N+1.
//   - Throughput: one beat per cycle with out_ready=1, i.e. RATIO cycles per word.
//   - Reset mid-word: the remaining beats of the popped word are discarded and are not counted.
//     The FIFO is not popped in the reset cycle.
//   - words_sent wraps from 2**cnt_width-1 to 0.
//   - The FIFO handles full/wrap internally. This block only guarantees no pop-on-empty.
// TESTING
//   1. Reset, then load 0xDDCCBBAA into the FIFO with out_ready=1.
//      -> One pop. Beats AA,BB,CC,DD on consecutive cycles, out_last on DD,
//         words_sent=1, then IDLE (busy=0).
//   2. msb_first=1, same word. -> Beats DD,CC,BB,AA.
//   3. Four words 0x03020100..0x0F0E0D0C queued, out_ready=1.
//      -> 16 beats 00..0F with no gap. out_last every 4th beat. Pops in the cycle of each
//         last beat. words_sent=4.
//   4. out_ready held 0 for 3 cycles on beat 2 of 0x44332211.
//      -> out_data=0x22 steady, no pop, beat_cnt unchanged. Beats resume 22,33,44 on release.
//   5. reset asserted after beat 1 of 0x88776655 while a second word is queued.
//      -> Next cycle out_valid=0, words_sent=0, no pop in the reset cycle.
//         After release the queued word is emitted in full.
//   6. cnt_width=2, five words sent. -> words_sent goes 1,2,3,0,1.
//      fifo_pop never asserted while fifo_empty=1 (assertion).

Source files
------------

// File: rtl/fifo_word_serializer.sv
// fifo_word_serializer
// Drains a word FIFO and streams each word out as RATIO narrower beats on a
// valid/ready interface, flagging the final beat of every word. A new word is
// popped in the same cycle as the last beat of the previous one when the FIFO
// is non-empty, so consecutive words stream without a bubble.

module fifo_word_serializer #(
  parameter int in_width  = 32,
  parameter int out_width = 8,
  parameter int msb_first = 0,
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [in_width-1:0]  fifo_data,
  output logic                 fifo_pop,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [out_width-1:0] out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic [cnt_width-1:0] words_sent
);

  localparam int RATIO = in_width / out_width;
  localparam int BCW   = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(RATIO - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [in_width-1:0]  shreg_q, shreg_d;
  logic [BCW-1:0]       beat_q, beat_d;
  logic [cnt_width-1:0] words_q, words_d;

  logic                 accept_s;
  logic                 last_s;
  logic                 pop_s;
  logic [in_width-1:0]  shifted_s;

  // Shift the held word one beat toward the emit end, zero-filling behind it.
  always_comb begin
    if (msb_first != 0) begin
      shifted_s = shreg_q << out_width;
    end else begin
      shifted_s = shreg_q >> out_width;
    end
  end

  // Next-state logic: load on pop, shift on accepted beats, count finished words.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    beat_d   = beat_q;
    words_d  = words_q;
    pop_s    = 1'b0;
    last_s   = (beat_q == LAST_BEAT);
    accept_s = (state_q == SEND) && out_ready;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop_s   = 1'b1;
          shreg_d = fifo_data;
          beat_d  = {BCW{1'b0}};
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (accept_s) begin
          if (last_s) begin
            words_d = words_q + cnt_width'(1);
            if (!fifo_empty) begin
              // Zero-bubble reload: next word is taken on the same edge.
              pop_s   = 1'b1;
              shreg_d = fifo_data;
              beat_d  = {BCW{1'b0}};
              state_d = SEND;
            end else begin
              shreg_d = shifted_s;
              beat_d  = {BCW{1'b0}};
              state_d = IDLE;
            end
          end else begin
            shreg_d = shifted_s;
            beat_d  = beat_q + BCW'(1);
          end
        end else begin
          // Stall: hold everything until the sink accepts.
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
        shreg_d = {in_width{1'b0}};
        beat_d  = {BCW{1'b0}};
      end
    endcase
  end

  // State registers with synchronous reset; reset discards any word in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= {in_width{1'b0}};
      beat_q  <= {BCW{1'b0}};
      words_q <= {cnt_width{1'b0}};
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      beat_q  <= beat_d;
      words_q <= words_d;
    end
  end

  // The FIFO must never be popped while reset is held.
  assign fifo_pop   = pop_s && !reset;

  assign out_valid  = (state_q == SEND);
  assign busy       = (state_q == SEND);
  assign out_last   = (state_q == SEND) && last_s;
  assign words_sent = words_q;

  generate
    if (msb_first != 0) begin : g_emit_msb
      assign out_data = shreg_q[in_width-1 -: out_width];
    end else begin : g_emit_lsb
      assign out_data = shreg_q[out_width-1:0];
    end
  endgenerate

endmodule
